// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, bubble encoding and control-field layout for stage registers
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;

    // Control value that performs no register or memory write.
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL_DEF = '0;

    // Bit positions inside the packed control payload, common to every stage register.
    localparam int CTRL_REGWR_BIT    = 0;
    localparam int CTRL_MEMWR_BIT    = 1;
    localparam int CTRL_MEMTOREG_BIT = 2;
    localparam int CTRL_NPCOP_LSB    = 3;
    localparam int CTRL_NPCOP_W      = 3;

    typedef struct packed {
        logic [1:0]              spare;
        logic [CTRL_NPCOP_W-1:0] npcop;
        logic                    memtoreg;
        logic                    memwr;
        logic                    regwr;
    } ctrl_fields_t;

    // True when a control word causes any architectural write.
    function automatic logic ctrl_has_side_effect(input logic [CTRL_W_DEF-1:0] c);
        return c[CTRL_REGWR_BIT] | c[CTRL_MEMWR_BIT];
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid/data/ctrl entry with load, clear-to-bubble and hold
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    // Clear wins over load; a cleared entry keeps its data but drops to a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_CTRL;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    // Entry state register; reset zeroes data and parks ctrl on the bubble value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= BUBBLE_CTRL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry and flush
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEF),
    parameter bit                SKID_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data,  skid_data;
    logic [CTRL_W-1:0] main_ctrl,  skid_ctrl;

    logic              main_load, main_clear, skid_load, skid_clear;
    logic [DATA_W-1:0] main_din;
    logic [CTRL_W-1:0] main_cin;
    logic              accept, issue;
    logic [1:0]        occ_q, occ_d;

    assign issue  = main_valid && out_ready;
    assign accept = in_valid && in_ready;

    // in_ready: with a skid entry it depends only on registered state (plus flush),
    // which breaks the combinational ready path back to the upstream stage.
    generate
        if (SKID_EN) begin : g_ready_skid
            assign in_ready = !skid_valid && !flush;
        end else begin : g_ready_single
            assign in_ready = (!main_valid || out_ready) && !flush;
        end
    endgenerate

    // Steering: skid drains into main first, otherwise new input fills main or skid.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_din   = in_data;
        main_cin   = in_ctrl;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            if (issue && skid_valid) begin
                main_load  = 1'b1;
                main_din   = skid_data;
                main_cin   = skid_ctrl;
                skid_clear = 1'b1;
            end else if (accept && (!main_valid || issue)) begin
                main_load = 1'b1;
            end else if (issue) begin
                main_clear = 1'b1;
            end
            if (accept && main_valid && !issue) begin
                skid_load = 1'b1;
            end
        end
    end

    pipe_slot #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .BUBBLE_CTRL(BUBBLE_CTRL)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load_i (main_load),
        .clear_i(main_clear),
        .data_i (main_din),
        .ctrl_i (main_cin),
        .valid_o(main_valid),
        .data_o (main_data),
        .ctrl_o (main_ctrl)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_slot #(
                .DATA_W     (DATA_W),
                .CTRL_W     (CTRL_W),
                .BUBBLE_CTRL(BUBBLE_CTRL)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load_i (skid_load),
                .clear_i(skid_clear),
                .data_i (in_data),
                .ctrl_i (in_ctrl),
                .valid_o(skid_valid),
                .data_o (skid_data),
                .ctrl_o (skid_ctrl)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = BUBBLE_CTRL;
        end
    endgenerate

    // Live-entry count: +1 on accept, -1 on issue, zeroed by flush.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else if (accept && !issue) begin
            occ_d = occ_q + 2'd1;
        end else if (issue && !accept) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table-driven bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Two-entry instance, default parameters.
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [1:0]  occupancy;

    // Single-entry instance with a non-zero bubble encoding.
    logic        b_rst, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [1:0]  b_occupancy;

    localparam logic [7:0] B_BUB = 8'h5A;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .BUBBLE_CTRL(B_BUB), .SKID_EN(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .occupancy(b_occupancy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, iv;
        logic [31:0] d;
        logic [7:0]  c;
        logic        fl, ordy;
        logic        chk_ir, exp_ir;
        logic        exp_ov;
        logic        chk_d;
        logic [31:0] exp_d;
        logic [7:0]  exp_c;
        logic [1:0]  exp_occ;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] d,
                                input logic [7:0] c, input logic fl, input logic ordy,
                                input logic chk_ir, input logic exp_ir, input logic exp_ov,
                                input logic chk_d, input logic [31:0] exp_d,
                                input logic [7:0] exp_c, input logic [1:0] exp_occ);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.c = c; v.fl = fl; v.ordy = ordy;
        v.chk_ir = chk_ir; v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.chk_d = chk_d;
        v.exp_d = exp_d; v.exp_c = exp_c; v.exp_occ = exp_occ;
        return v;
    endfunction

    vec_t vt[17];

    initial begin
        // Watchdog so the run always ends.
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1; in_valid = 0; in_data = 0; in_ctrl = 0; flush = 0; out_ready = 0;
        b_rst = 1; b_in_valid = 0; b_in_data = 0; b_in_ctrl = 0; b_flush = 0; b_out_ready = 0;

        //          rst iv data      ctrl   fl ordy cir eir ov cd  exp_d     exp_c  occ
        vt[0]  = mk(1, 0, 32'h0,    8'h00, 0, 0,   0, 0,  0, 1, 32'h0,    8'h00, 2'd0); // reset
        vt[1]  = mk(0, 1, 32'h1234, 8'h11, 0, 1,   1, 1,  1, 1, 32'h1234, 8'h11, 2'd1); // 1-cycle latency
        vt[2]  = mk(0, 0, 32'h0,    8'h00, 0, 1,   1, 1,  0, 0, 32'h0,    8'h00, 2'd0); // drain -> bubble
        vt[3]  = mk(0, 1, 32'h1,    8'h21, 0, 0,   1, 1,  1, 1, 32'h1,    8'h21, 2'd1); // 0x1 into main
        vt[4]  = mk(0, 1, 32'h2,    8'h22, 0, 0,   1, 1,  1, 1, 32'h1,    8'h21, 2'd2); // 0x2 into skid, main holds
        vt[5]  = mk(0, 1, 32'h3,    8'h23, 0, 0,   1, 0,  1, 1, 32'h1,    8'h21, 2'd2); // full, refused
        vt[6]  = mk(0, 1, 32'h3,    8'h23, 0, 1,   1, 0,  1, 1, 32'h2,    8'h22, 2'd1); // 0x1 out, skid->main
        vt[7]  = mk(0, 1, 32'h3,    8'h23, 0, 1,   1, 1,  1, 1, 32'h3,    8'h23, 2'd1); // 0x2 out, 0x3 in
        vt[8]  = mk(0, 0, 32'h0,    8'h00, 0, 1,   1, 1,  0, 0, 32'h0,    8'h00, 2'd0); // 0x3 out
        vt[9]  = mk(0, 1, 32'hA,    8'h31, 0, 0,   1, 1,  1, 1, 32'hA,    8'h31, 2'd1);
        vt[10] = mk(0, 1, 32'hB,    8'h32, 0, 0,   1, 1,  1, 1, 32'hA,    8'h31, 2'd2);
        vt[11] = mk(0, 1, 32'hC,    8'h33, 1, 1,   1, 0,  0, 0, 32'h0,    8'h00, 2'd0); // flush full stage
        vt[12] = mk(0, 0, 32'h0,    8'h00, 0, 1,   1, 1,  0, 0, 32'h0,    8'h00, 2'd0); // nothing survived
        vt[13] = mk(0, 1, 32'hD,    8'h41, 0, 0,   1, 1,  1, 1, 32'hD,    8'h41, 2'd1);
        vt[14] = mk(0, 1, 32'hE,    8'h42, 0, 0,   1, 1,  1, 1, 32'hD,    8'h41, 2'd2);
        vt[15] = mk(1, 1, 32'hF,    8'h43, 0, 1,   1, 0,  0, 1, 32'h0,    8'h00, 2'd0); // reset while full
        vt[16] = mk(0, 0, 32'h0,    8'h00, 0, 0,   1, 1,  0, 1, 32'h0,    8'h00, 2'd0); // ready after reset

        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            rst = vt[i].rst; in_valid = vt[i].iv; in_data = vt[i].d; in_ctrl = vt[i].c;
            flush = vt[i].fl; out_ready = vt[i].ordy;
            #1;
            if (vt[i].chk_ir) chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vt[i].exp_ir});
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].exp_ov});
            chk($sformatf("v%0d out_ctrl", i), {24'b0, out_ctrl}, {24'b0, vt[i].exp_c});
            chk($sformatf("v%0d occupancy", i), {30'b0, occupancy}, {30'b0, vt[i].exp_occ});
            if (vt[i].chk_d) chk($sformatf("v%0d out_data", i), out_data, vt[i].exp_d);
        end

        // Streaming: one accept and one issue per cycle, data 0..7.
        out_ready = 1; flush = 0; rst = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 32'(i); in_ctrl = 8'(8'h80 + i);
            #1;
            chk($sformatf("stream%0d in_ready", i), {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("stream%0d out_data", i), out_data, 32'(i));
            chk($sformatf("stream%0d out_ctrl", i), {24'b0, out_ctrl}, 32'(8'h80 + i));
            chk($sformatf("stream%0d occupancy", i), {30'b0, occupancy}, 32'd1);
        end
        in_valid = 0;
        @(posedge clk); #1;
        chk("stream_drain out_valid", {31'b0, out_valid}, 32'd0);

        // Single-entry instance: stall back-pressure and same-cycle issue+accept.
        @(posedge clk); #1;
        chk("b reset out_ctrl", {24'b0, b_out_ctrl}, {24'b0, B_BUB});
        chk("b reset occupancy", {30'b0, b_occupancy}, 32'd0);
        b_rst = 0;
        #1;
        chk("b in_ready after reset", {31'b0, b_in_ready}, 32'd1);
        b_in_valid = 1; b_in_data = 32'h77; b_in_ctrl = 8'h01; b_out_ready = 0;
        @(posedge clk); #1;
        chk("b load out_data", b_out_data, 32'h77);
        b_in_data = 32'h88; b_in_ctrl = 8'h02;
        #1;
        chk("b stalled in_ready", {31'b0, b_in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b stalled out_data", b_out_data, 32'h77);
        chk("b stalled occupancy", {30'b0, b_occupancy}, 32'd1);
        b_out_ready = 1;
        #1;
        chk("b issue in_ready", {31'b0, b_in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("b swap out_data", b_out_data, 32'h88);
        chk("b swap out_ctrl", {24'b0, b_out_ctrl}, 32'h02);
        chk("b swap occupancy", {30'b0, b_occupancy}, 32'd1);
        b_in_valid = 0;
        @(posedge clk); #1;
        chk("b empty out_valid", {31'b0, b_out_valid}, 32'd0);
        chk("b empty out_ctrl", {24'b0, b_out_ctrl}, {24'b0, B_BUB});
        chk("b empty occupancy", {30'b0, b_occupancy}, 32'd0);
        // Flush of a held entry restores the bubble encoding.
        b_in_valid = 1; b_in_data = 32'h99; b_in_ctrl = 8'h03; b_out_ready = 0;
        @(posedge clk); #1;
        b_flush = 1; b_in_data = 32'hAA;
        #1;
        chk("b flush in_ready", {31'b0, b_in_ready}, 32'd0);
        @(posedge clk); #1;
        b_flush = 0; b_in_valid = 0;
        chk("b flush out_valid", {31'b0, b_out_valid}, 32'd0);
        chk("b flush out_ctrl", {24'b0, b_out_ctrl}, {24'b0, B_BUB});
        chk("b flush occupancy", {30'b0, b_occupancy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
